ddr4_app_arbiter: RTL and testbench

Two-port round-robin arbiter sharing the mem_clk-side DDR4 application interface (the bridge_app_* port of the DDR4 clock-domain synchroniser) between two requesters. Typical requesters: the TCU memory bridge and a debug/DMA port. Tracks outstanding reads in an in-order owner FIFO, so every returning read beat is steered back to the requester that issued it. Sits entirely in the mem_clk domain, directly upstream of the synchroniser.

---
 rtl/ddr4_app_arbiter.sv | 147 ++++++++++++++
 tb/tb_ddr4_app_arbiter.sv | 399 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr4_app_arbiter.sv
// Two-port round-robin arbiter in front of the DDR4 app interface (mem_clk domain).
// An in-order owner FIFO steers each returning read beat back to the requester that issued it.
module ddr4_app_arbiter #(
  parameter int DDR4_APP_ADDR_WIDTH = 28,
  parameter int DDR4_APP_CMD_WIDTH  = 3,
  parameter int DDR4_APP_DATA_WIDTH = 64,
  parameter int MAX_OUTSTANDING     = 16
) (
  input  logic                                 mem_clk_i,
  input  logic                                 mem_rst_i,

  input  logic                                 req0_en_i,
  input  logic [DDR4_APP_CMD_WIDTH-1:0]        req0_cmd_i,
  input  logic [DDR4_APP_ADDR_WIDTH-1:0]       req0_addr_i,
  input  logic [DDR4_APP_DATA_WIDTH-1:0]       req0_wdata_i,
  input  logic [DDR4_APP_DATA_WIDTH/8-1:0]     req0_wmask_i,
  output logic                                 req0_rdy_o,
  output logic [DDR4_APP_DATA_WIDTH-1:0]       req0_rd_data_o,
  output logic                                 req0_rd_valid_o,

  input  logic                                 req1_en_i,
  input  logic [DDR4_APP_CMD_WIDTH-1:0]        req1_cmd_i,
  input  logic [DDR4_APP_ADDR_WIDTH-1:0]       req1_addr_i,
  input  logic [DDR4_APP_DATA_WIDTH-1:0]       req1_wdata_i,
  input  logic [DDR4_APP_DATA_WIDTH/8-1:0]     req1_wmask_i,
  output logic                                 req1_rdy_o,
  output logic [DDR4_APP_DATA_WIDTH-1:0]       req1_rd_data_o,
  output logic                                 req1_rd_valid_o,

  output logic [DDR4_APP_ADDR_WIDTH-1:0]       bridge_app_addr_o,
  output logic [DDR4_APP_CMD_WIDTH-1:0]        bridge_app_cmd_o,
  output logic                                 bridge_app_en_o,
  output logic [DDR4_APP_DATA_WIDTH-1:0]       bridge_app_wdf_data_o,
  output logic [DDR4_APP_DATA_WIDTH/8-1:0]     bridge_app_wdf_mask_o,
  output logic                                 bridge_app_wdf_wren_o,
  output logic                                 bridge_app_wdf_end_o,
  input  logic                                 bridge_app_rdy_i,
  input  logic                                 bridge_app_wdf_rdy_i,
  input  logic [DDR4_APP_DATA_WIDTH-1:0]       bridge_app_rd_data_i,
  input  logic                                 bridge_app_rd_data_valid_i,
  input  logic                                 bridge_app_rd_data_end_i,

  output logic [$clog2(MAX_OUTSTANDING):0]     outstanding_o,
  output logic                                 err_o
);

  localparam int PTR_W = $clog2(MAX_OUTSTANDING);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);
  localparam logic [DDR4_APP_CMD_WIDTH-1:0] APP_CMD_WRITE = DDR4_APP_CMD_WIDTH'(0);
  localparam logic [DDR4_APP_CMD_WIDTH-1:0] APP_CMD_READ  = DDR4_APP_CMD_WIDTH'(1);

  if ((MAX_OUTSTANDING < 2) || ((MAX_OUTSTANDING & (MAX_OUTSTANDING - 1)) != 0)) begin : g_bad_depth
    $error("MAX_OUTSTANDING must be a power of two and at least 2");
  end

  logic [MAX_OUTSTANDING-1:0] owner_q, owner_d;
  logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic                       last_grant_q, last_grant_d;
  logic                       err_q, err_d;

  logic rd0, rd1, fifo_full, fifo_empty, bus_rdy;
  logic elig0, elig1, gnt0, gnt1, grant, sel_rd;
  logic push, pop, pop_owner;

  always_comb begin
    rd0        = (req0_cmd_i == APP_CMD_READ);
    rd1        = (req1_cmd_i == APP_CMD_READ);
    fifo_full  = (cnt_q == CNT_MAX);
    fifo_empty = (cnt_q == '0);
    bus_rdy    = bridge_app_rdy_i & bridge_app_wdf_rdy_i;

    // A full owner FIFO only blocks reads; writes pass straight through.
    elig0 = req0_en_i & bus_rdy & ~(rd0 & fifo_full);
    elig1 = req1_en_i & bus_rdy & ~(rd1 & fifo_full);

    // On contention the requester that did not win last time takes the bus.
    gnt0  = elig0 & (~elig1 | last_grant_q);
    gnt1  = elig1 & (~elig0 | ~last_grant_q);
    grant = gnt0 | gnt1;

    sel_rd    = gnt1 ? rd1 : rd0;
    push      = grant & sel_rd;
    pop       = bridge_app_rd_data_valid_i & bridge_app_rd_data_end_i & ~fifo_empty;
    pop_owner = owner_q[rd_ptr_q];
  end

  always_comb begin
    req0_rdy_o            = gnt0;
    req1_rdy_o            = gnt1;
    bridge_app_en_o       = grant;
    bridge_app_addr_o     = gnt1 ? req1_addr_i  : req0_addr_i;
    bridge_app_cmd_o      = grant ? (gnt1 ? req1_cmd_i : req0_cmd_i) : APP_CMD_WRITE;
    bridge_app_wdf_data_o = gnt1 ? req1_wdata_i : req0_wdata_i;
    bridge_app_wdf_mask_o = gnt1 ? req1_wmask_i : req0_wmask_i;
    bridge_app_wdf_wren_o = grant & ~sel_rd;
    bridge_app_wdf_end_o  = grant & ~sel_rd;

    req0_rd_data_o  = bridge_app_rd_data_i;
    req1_rd_data_o  = bridge_app_rd_data_i;
    req0_rd_valid_o = pop & ~pop_owner;
    req1_rd_valid_o = pop &  pop_owner;

    outstanding_o = cnt_q;
    err_o         = err_q;
  end

  always_comb begin
    owner_d = owner_q;
    if (push) owner_d[wr_ptr_q] = gnt1;

    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);

    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase

    last_grant_d = grant ? gnt1 : last_grant_q;
    // Beats with nothing in flight are dropped and flagged until reset.
    err_d = err_q | (bridge_app_rd_data_valid_i & fifo_empty);
  end

  always_ff @(posedge mem_clk_i or posedge mem_rst_i) begin
    if (mem_rst_i) begin
      owner_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      last_grant_q <= 1'b1;
      err_q        <= 1'b0;
    end else begin
      owner_q      <= owner_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      err_q        <= err_d;
    end
  end

endmodule

// File: tb/tb_ddr4_app_arbiter.sv
// Bench for ddr4_app_arbiter: directed scenarios plus a randomized run against a
// queue-based model of grants, owner order and error flagging.
module tb_ddr4_app_arbiter;

  localparam int AW  = 28;
  localparam int CW  = 3;
  localparam int DW  = 64;
  localparam int MW  = DW / 8;
  localparam int MAX = 16;
  localparam int OW  = $clog2(MAX) + 1;
  localparam logic [CW-1:0] WR = 3'd0;
  localparam logic [CW-1:0] RD = 3'd1;

  logic clk = 1'b0;
  logic rst;
  logic [1:0]    en;
  logic [CW-1:0] cmd   [2];
  logic [AW-1:0] addr  [2];
  logic [DW-1:0] wdata [2];
  logic [MW-1:0] wmask [2];
  logic rdy0, rdy1, rv0, rv1;
  logic [DW-1:0] rdd0, rdd1;
  logic [AW-1:0] b_addr;
  logic [CW-1:0] b_cmd;
  logic b_en, b_wren, b_wend;
  logic [DW-1:0] b_wdata;
  logic [MW-1:0] b_wmask;
  logic brdy, wrdy, rvalid, rend;
  logic [DW-1:0] rdata;
  logic [OW-1:0] outstanding;
  logic err;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  ddr4_app_arbiter #(
    .DDR4_APP_ADDR_WIDTH(AW), .DDR4_APP_CMD_WIDTH(CW),
    .DDR4_APP_DATA_WIDTH(DW), .MAX_OUTSTANDING(MAX)
  ) dut (
    .mem_clk_i(clk), .mem_rst_i(rst),
    .req0_en_i(en[0]), .req0_cmd_i(cmd[0]), .req0_addr_i(addr[0]),
    .req0_wdata_i(wdata[0]), .req0_wmask_i(wmask[0]), .req0_rdy_o(rdy0),
    .req0_rd_data_o(rdd0), .req0_rd_valid_o(rv0),
    .req1_en_i(en[1]), .req1_cmd_i(cmd[1]), .req1_addr_i(addr[1]),
    .req1_wdata_i(wdata[1]), .req1_wmask_i(wmask[1]), .req1_rdy_o(rdy1),
    .req1_rd_data_o(rdd1), .req1_rd_valid_o(rv1),
    .bridge_app_addr_o(b_addr), .bridge_app_cmd_o(b_cmd), .bridge_app_en_o(b_en),
    .bridge_app_wdf_data_o(b_wdata), .bridge_app_wdf_mask_o(b_wmask),
    .bridge_app_wdf_wren_o(b_wren), .bridge_app_wdf_end_o(b_wend),
    .bridge_app_rdy_i(brdy), .bridge_app_wdf_rdy_i(wrdy),
    .bridge_app_rd_data_i(rdata), .bridge_app_rd_data_valid_i(rvalid),
    .bridge_app_rd_data_end_i(rend),
    .outstanding_o(outstanding), .err_o(err)
  );

  // Reference model: previous winner, queue of read owners in issue order, sticky error.
  int m_last;
  int m_q[$];
  bit m_err;
  int exp_win;
  int exp_owner;
  bit exp_spur;
  logic [6:0] exp_vec;
  logic [6:0] dut_vec;

  assign dut_vec = {rdy1, rdy0, b_en, b_wren, b_wend, rv1, rv0};

  task automatic model_reset();
    m_last = 1;
    m_q.delete();
    m_err = 1'b0;
  endtask

  task automatic model_eval();
    bit el [2];
    bit full;
    bit is_wr;
    full = (m_q.size() == MAX);
    for (int n = 0; n < 2; n++)
      el[n] = en[n] && brdy && wrdy && !(cmd[n] == RD && full);
    if (el[0] && el[1]) exp_win = 1 - m_last;
    else if (el[0])     exp_win = 0;
    else if (el[1])     exp_win = 1;
    else                exp_win = -1;
    exp_owner = (rvalid && rend && m_q.size() > 0) ? m_q[0] : -1;
    exp_spur  = rvalid && (m_q.size() == 0);
    is_wr     = (exp_win >= 0) ? (cmd[exp_win] != RD) : 1'b0;
    exp_vec   = {exp_win == 1, exp_win == 0, exp_win >= 0, is_wr, is_wr,
                 exp_owner == 1, exp_owner == 0};
  endtask

  task automatic model_commit();
    if (exp_owner >= 0) void'(m_q.pop_front());
    if (exp_win >= 0) begin
      m_last = exp_win;
      if (cmd[exp_win] == RD) m_q.push_back(exp_win);
    end
    if (exp_spur) m_err = 1'b1;
  endtask

  task automatic at_sample();
    @(negedge clk);
    model_eval();
  endtask

  task automatic at_edge();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic idle_inputs();
    en = 2'b00;
    brdy = 1'b1; wrdy = 1'b1;
    rvalid = 1'b0; rend = 1'b0; rdata = '0;
    for (int n = 0; n < 2; n++) begin
      cmd[n] = WR; addr[n] = '0; wdata[n] = '0; wmask[n] = '0;
    end
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    at_sample();
    tests_run++;
    if (dut_vec !== 7'b0) begin
      tests_failed++; $display("FAIL reset_outputs: got %b expected %b", dut_vec, 7'b0);
    end
    tests_run++;
    if (outstanding !== '0 || err !== 1'b0) begin
      tests_failed++; $display("FAIL reset_state: got out=%0d err=%b expected 0 0", outstanding, err);
    end
    at_edge();
  endtask

  task automatic test_single_write();
    do_reset();
    cmd[0] = WR; addr[0] = AW'(32'h40); wdata[0] = {8{8'hA5}}; wmask[0] = '0; en = 2'b01;
    at_sample();
    tests_run++;
    if (dut_vec !== 7'b0111100) begin
      tests_failed++; $display("FAIL single_write_ctrl: got %b expected %b", dut_vec, 7'b0111100);
    end
    tests_run++;
    if (b_addr !== AW'(32'h40) || b_cmd !== WR || b_wdata !== {8{8'hA5}} || b_wmask !== '0) begin
      tests_failed++;
      $display("FAIL single_write_bus: got addr=%0h cmd=%0d data=%0h mask=%0h expected 40 0 %0h 0",
               b_addr, b_cmd, b_wdata, b_wmask, {8{8'hA5}});
    end
    at_edge();
    en = 2'b00;
    at_sample();
    tests_run++;
    if (outstanding !== '0 || b_en !== 1'b0) begin
      tests_failed++; $display("FAIL single_write_after: got out=%0d en=%b expected 0 0", outstanding, b_en);
    end
    at_edge();
  endtask

  task automatic test_contention();
    logic [DW-1:0] beat;
    do_reset();
    cmd[0] = RD; cmd[1] = RD;
    addr[0] = AW'($urandom); addr[1] = AW'($urandom);
    en = 2'b11;
    for (int i = 0; i < 4; i++) begin
      at_sample();
      tests_run++;
      if (rdy0 !== (i % 2 == 0) || rdy1 !== (i % 2 == 1) || dut_vec !== exp_vec) begin
        tests_failed++;
        $display("FAIL contention_grant[%0d]: got %b expected rdy0=%0d rdy1=%0d vec=%b",
                 i, dut_vec, i % 2 == 0, i % 2 == 1, exp_vec);
      end
      tests_run++;
      if (b_addr !== addr[i % 2] || b_cmd !== RD) begin
        tests_failed++; $display("FAIL contention_addr[%0d]: got %0h expected %0h", i, b_addr, addr[i % 2]);
      end
      at_edge();
    end
    en = 2'b00;
    for (int i = 0; i < 4; i++) begin
      beat = {$urandom, $urandom};
      rdata = beat; rvalid = 1'b1; rend = 1'b1;
      at_sample();
      tests_run++;
      if (rv0 !== (i % 2 == 0) || rv1 !== (i % 2 == 1) || rdd0 !== beat || rdd1 !== beat) begin
        tests_failed++;
        $display("FAIL contention_return[%0d]: got rv0=%b rv1=%b d0=%0h d1=%0h expected rv0=%0d rv1=%0d d=%0h",
                 i, rv0, rv1, rdd0, rdd1, i % 2 == 0, i % 2 == 1, beat);
      end
      at_edge();
    end
    rvalid = 1'b0; rend = 1'b0;
    at_sample();
    tests_run++;
    if (outstanding !== '0 || err !== 1'b0) begin
      tests_failed++; $display("FAIL contention_drain: got out=%0d err=%b expected 0 0", outstanding, err);
    end
    at_edge();
  endtask

  task automatic test_backpressure();
    do_reset();
    cmd[1] = WR; addr[1] = AW'($urandom); wdata[1] = {$urandom, $urandom}; en = 2'b10;
    brdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      at_sample();
      tests_run++;
      if (b_en !== 1'b0 || rdy1 !== 1'b0 || b_wren !== 1'b0) begin
        tests_failed++; $display("FAIL backpressure_hold[%0d]: got en=%b rdy1=%b expected 0 0", i, b_en, rdy1);
      end
      at_edge();
    end
    brdy = 1'b1;
    at_sample();
    tests_run++;
    if (dut_vec !== 7'b1011100 || b_addr !== addr[1] || b_wdata !== wdata[1]) begin
      tests_failed++; $display("FAIL backpressure_release: got %b addr=%0h expected %b addr=%0h",
                               dut_vec, b_addr, 7'b1011100, addr[1]);
    end
    at_edge();
    en = 2'b00;
  endtask

  task automatic test_fifo_full();
    do_reset();
    cmd[0] = RD; en = 2'b01;
    for (int i = 0; i < MAX; i++) begin
      addr[0] = AW'(i * 64);
      at_sample();
      tests_run++;
      if (dut_vec !== exp_vec) begin
        tests_failed++; $display("FAIL full_fill[%0d]: got %b expected %b", i, dut_vec, exp_vec);
      end
      at_edge();
    end
    at_sample();
    tests_run++;
    if (outstanding !== OW'(MAX) || rdy0 !== 1'b0 || b_en !== 1'b0) begin
      tests_failed++; $display("FAIL full_stall: got out=%0d rdy0=%b expected %0d 0", outstanding, rdy0, MAX);
    end
    at_edge();
    en = 2'b10; cmd[1] = WR;
    at_edge();
    en = 2'b11;
    at_sample();
    tests_run++;
    if (rdy1 !== 1'b1 || rdy0 !== 1'b0 || b_wren !== 1'b1 || dut_vec !== exp_vec) begin
      tests_failed++; $display("FAIL full_write_passes: got %b expected rdy1=1 rdy0=0 vec=%b", dut_vec, exp_vec);
    end
    at_edge();
    en = 2'b01; rvalid = 1'b1; rend = 1'b1; rdata = {$urandom, $urandom};
    at_sample();
    tests_run++;
    if (rv0 !== 1'b1 || rdy0 !== 1'b0) begin
      tests_failed++; $display("FAIL full_return: got rv0=%b rdy0=%b expected 1 0", rv0, rdy0);
    end
    at_edge();
    rvalid = 1'b0; rend = 1'b0;
    at_sample();
    tests_run++;
    if (outstanding !== OW'(MAX - 1) || rdy0 !== 1'b1) begin
      tests_failed++; $display("FAIL full_resume: got out=%0d rdy0=%b expected %0d 1", outstanding, rdy0, MAX - 1);
    end
    at_edge();
    en = 2'b00;
  endtask

  task automatic test_push_pop_wrap();
    int reads;
    do_reset();
    cmd[0] = RD; en = 2'b01;
    repeat (3) begin at_sample(); at_edge(); end
    rvalid = 1'b1; rend = 1'b1;
    at_sample(); at_edge();
    rvalid = 1'b0; rend = 1'b0; en = 2'b00;
    tests_run++;
    if (outstanding !== OW'(3)) begin
      tests_failed++; $display("FAIL push_pop_same_cycle: got %0d expected 3", outstanding);
    end
    reads = 0;
    for (int c = 0; c < 800; c++) begin
      for (int n = 0; n < 2; n++) begin
        en[n]    = ($urandom_range(0, 3) != 0);
        cmd[n]   = ($urandom_range(0, 2) != 0) ? RD : WR;
        addr[n]  = AW'($urandom);
        wdata[n] = {$urandom, $urandom};
        wmask[n] = MW'($urandom);
      end
      brdy   = ($urandom_range(0, 9) != 0);
      wrdy   = ($urandom_range(0, 9) != 0);
      rvalid = (m_q.size() > 0) && ($urandom_range(0, 1) == 1);
      rend   = rvalid;
      rdata  = {$urandom, $urandom};
      at_sample();
      tests_run++;
      if (dut_vec !== exp_vec || outstanding !== OW'(m_q.size())) begin
        tests_failed++; $display("FAIL random_cycle[%0d]: got %b out=%0d expected %b out=%0d",
                                 c, dut_vec, outstanding, exp_vec, m_q.size());
      end
      if (exp_win >= 0) begin
        tests_run++;
        if (b_addr !== addr[exp_win] || b_cmd !== cmd[exp_win] ||
            (cmd[exp_win] == WR && (b_wdata !== wdata[exp_win] || b_wmask !== wmask[exp_win]))) begin
          tests_failed++; $display("FAIL random_bus[%0d]: got addr=%0h cmd=%0d expected addr=%0h cmd=%0d",
                                   c, b_addr, b_cmd, addr[exp_win], cmd[exp_win]);
        end
        if (cmd[exp_win] == RD) reads++;
      end
      if (exp_owner >= 0) begin
        tests_run++;
        if (rdd0 !== rdata || rdd1 !== rdata) begin
          tests_failed++; $display("FAIL random_rdata[%0d]: got %0h/%0h expected %0h", c, rdd0, rdd1, rdata);
        end
      end
      at_edge();
    end
    idle_inputs();
    at_sample();
    tests_run++;
    if (err !== 1'b0 || reads < 40) begin
      tests_failed++; $display("FAIL random_end: got err=%b reads=%0d expected err=0 reads>=40", err, reads);
    end
    at_edge();
  endtask

  task automatic test_spurious();
    do_reset();
    rvalid = 1'b1; rend = 1'b1; rdata = {$urandom, $urandom};
    at_sample();
    tests_run++;
    if (rv0 !== 1'b0 || rv1 !== 1'b0) begin
      tests_failed++; $display("FAIL spurious_drop: got rv0=%b rv1=%b expected 0 0", rv0, rv1);
    end
    at_edge();
    rvalid = 1'b0; rend = 1'b0;
    for (int i = 0; i < 3; i++) begin
      at_sample();
      tests_run++;
      if (err !== 1'b1 || outstanding !== '0) begin
        tests_failed++; $display("FAIL spurious_sticky[%0d]: got err=%b out=%0d expected 1 0", i, err, outstanding);
      end
      at_edge();
    end
    rst = 1'b1;
    #1;
    tests_run++;
    if (err !== 1'b0) begin
      tests_failed++; $display("FAIL spurious_async_clear: got %b expected 0", err);
    end
    @(posedge clk); #1; rst = 1'b0; model_reset();
    cmd[0] = RD; en = 2'b01;
    repeat (2) begin at_sample(); at_edge(); end
    tests_run++;
    if (outstanding !== OW'(2)) begin
      tests_failed++; $display("FAIL midop_issue: got %0d expected 2", outstanding);
    end
    do_reset();
    rvalid = 1'b1; rend = 1'b1;
    at_sample();
    tests_run++;
    if (rv0 !== 1'b0 || rv1 !== 1'b0) begin
      tests_failed++; $display("FAIL midop_beat_drop: got rv0=%b rv1=%b expected 0 0", rv0, rv1);
    end
    at_edge();
    rvalid = 1'b0; rend = 1'b0;
    tests_run++;
    if (err !== 1'b1 || outstanding !== '0) begin
      tests_failed++; $display("FAIL midop_err: got err=%b out=%0d expected 1 0", err, outstanding);
    end
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    model_reset();
    test_reset();
    test_single_write();
    test_contention();
    test_backpressure();
    test_fifo_full();
    test_push_pop_wrap();
    test_spurious();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
